// File: rtl/sat_requant_pipe.sv
//------------------------------------------------------------------------------
// Module     : sat_requant_pipe
// Description: Two-stage requantiser for CHANNELS signed accumulator lanes.
//              S1 applies an arithmetic right shift with optional round-half-up.
//              S2 clamps each lane to OUT_W signed bits and reports saturation.
//              The output side uses valid/ready flow control and keeps a
//              per-lane sticky saturation flag.
//              Optional macro SAT_REQUANT_STATS_EN adds a 32-bit saturating
//              count of saturated lanes delivered (sat_count).
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sat_requant_pipe #(
    parameter int ACC_W    = 40,
    parameter int OUT_W    = 16,
    parameter int CHANNELS = 2,
    parameter int SHIFT_W  = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [SHIFT_W-1:0]          shift_amt,
    input  logic                        round_en,
    input  logic [CHANNELS*ACC_W-1:0]   in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [CHANNELS*OUT_W-1:0]   out_data,
    output logic [CHANNELS-1:0]         out_sat,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CHANNELS-1:0]         sat_sticky,
    input  logic                        sticky_clr
`ifdef SAT_REQUANT_STATS_EN
    ,
    output logic [31:0]                 sat_count
`endif
);

    // Constants in the widened (ACC_W+1)-bit arithmetic domain
    localparam logic [31:0]        c_SHIFT_MAX = 32'(ACC_W - 1);
    localparam logic signed [ACC_W:0] c_ZERO = '0;
    localparam logic signed [ACC_W:0] c_ONE  = {{ACC_W{1'b0}}, 1'b1};
    localparam logic signed [ACC_W:0] c_MAX  = (c_ONE <<< (OUT_W - 1)) - c_ONE;
    localparam logic signed [ACC_W:0] c_MIN  = c_ZERO - (c_ONE <<< (OUT_W - 1));

    // Pipeline state
    logic                                  s1_valid_q;
    logic [CHANNELS-1:0][ACC_W:0]          s1_y_q;
    logic                                  out_valid_q;
    logic [CHANNELS-1:0][OUT_W-1:0]        out_data_q;
    logic [CHANNELS-1:0]                   out_sat_q;
    logic [CHANNELS-1:0]                   sticky_q;
    logic [CHANNELS-1:0]                   sticky_d;

    // Combinational datapath results
    logic [31:0]                           w_shift_eff;
    logic signed [ACC_W:0]                 w_rnd;
    logic [CHANNELS-1:0][ACC_W:0]          w_y;
    logic [CHANNELS-1:0][OUT_W-1:0]        w_out_d;
    logic [CHANNELS-1:0]                   w_sat_d;

    // Flow control
    logic                                  w_s2_load;
    logic                                  w_in_xfer;
    logic                                  w_out_xfer;

    // S2 refills when empty or when its beat leaves this cycle; S1 follows
    // the same condition, so in_ready depends only on state and out_ready.
    assign w_s2_load  = !out_valid_q || out_ready;
    assign in_ready   = !s1_valid_q || w_s2_load;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid_q && out_ready;

    // Shift amounts beyond the lane width behave as the widest legal shift
    assign w_shift_eff = (32'(shift_amt) > c_SHIFT_MAX) ? c_SHIFT_MAX : 32'(shift_amt);

    // Rounding adds half an LSB of the result; a zero shift has nothing to round
    assign w_rnd = (round_en && (w_shift_eff != 32'd0)) ?
                   (c_ONE << (w_shift_eff - 32'd1)) : c_ZERO;

    generate
        for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
            logic signed [ACC_W:0] w_x;
            logic signed [ACC_W:0] w_shifted;
            logic signed [ACC_W:0] w_ys;
            logic                  w_hi;
            logic                  w_lo;

            // One guard bit keeps the rounding addend from wrapping
            assign w_x       = {in_data[k*ACC_W + ACC_W - 1], in_data[k*ACC_W +: ACC_W]};
            assign w_shifted = (w_x + w_rnd) >>> w_shift_eff;
            assign w_y[k]    = w_shifted;

            assign w_ys = s1_y_q[k];
            assign w_hi = (w_ys > c_MAX);
            assign w_lo = (w_ys < c_MIN);

            assign w_out_d[k] = w_hi ? c_MAX[OUT_W-1:0] :
                                w_lo ? c_MIN[OUT_W-1:0] :
                                       w_ys[OUT_W-1:0];
            assign w_sat_d[k] = w_hi || w_lo;
        end
    endgenerate

    // A new saturation event wins over a simultaneous clear
    assign sticky_d = (sticky_q & ~{CHANNELS{sticky_clr}}) |
                      ({CHANNELS{w_out_xfer}} & out_sat_q);

    // S1 register: shifted/rounded lanes captured on each accepted beat
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_y_q     <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
            end
            if (w_in_xfer) begin
                s1_y_q <= w_y;
            end
        end
    end

    // S2 register: clamped output beat, held while downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= '0;
            sticky_q    <= '0;
        end else begin
            if (w_s2_load) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_data_q <= w_out_d;
                    out_sat_q  <= w_sat_d;
                end
            end
            sticky_q <= sticky_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_sat    = out_sat_q;
    assign sat_sticky = sticky_q;

`ifdef SAT_REQUANT_STATS_EN
    logic [31:0] sat_count_q;
    logic [32:0] w_sat_inc;
    logic [32:0] w_cnt_sum;
    logic [31:0] w_cnt_base;

    // Number of saturated lanes in the beat leaving this cycle
    always_comb begin
        w_sat_inc = '0;
        if (w_out_xfer) begin
            for (int k = 0; k < CHANNELS; k++) begin
                w_sat_inc = w_sat_inc + 33'(out_sat_q[k]);
            end
        end
    end

    assign w_cnt_base = sticky_clr ? 32'd0 : sat_count_q;
    assign w_cnt_sum  = {1'b0, w_cnt_base} + w_sat_inc;

    // Saturating event counter; a clear coinciding with events keeps the events
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_count_q <= '0;
        end else begin
            sat_count_q <= w_cnt_sum[32] ? 32'hFFFF_FFFF : w_cnt_sum[31:0];
        end
    end

    assign sat_count = sat_count_q;
`endif

endmodule

`default_nettype wire
